// File: rtl/multicore_sysid_regs_pkg.sv
// Shared definitions for the multicore system-ID register block:
// register word addresses, CTRL bit positions and the byte-lane merge helper.
package multicore_sysid_pkg;

  typedef logic [31:0] word_t;

  // Word addresses of the fixed registers; scratch words follow ADDR_SCRATCH0.
  localparam int ADDR_SYSID    = 0;
  localparam int ADDR_TS       = 1;
  localparam int ADDR_INFO     = 2;
  localparam int ADDR_CTRL     = 3;
  localparam int ADDR_UPLO     = 4;
  localparam int ADDR_UPHI     = 5;
  localparam int ADDR_SCRATCH0 = 6;

  // CTRL register bit positions.
  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;

  // Replace only the byte lanes whose enable bit is set.
  function automatic word_t apply_byteenable(input word_t      old_word,
                                             input word_t      new_word,
                                             input logic [3:0] be);
    word_t merged;
    merged = old_word;
    for (int lane = 0; lane < 4; lane++) begin
      if (be[lane]) merged[lane*8 +: 8] = new_word[lane*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/multicore_sysid_regs_if.sv
// Avalon-MM slave bus bundle for the system-ID block (no waitrequest).
interface multicore_sysid_regs_if
  import multicore_sysid_pkg::*;
#(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  word_t             writedata;
  logic [3:0]        byteenable;
  word_t             readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/multicore_sysid_regs_read_pipe.sv
// Fixed-latency read-return pipeline: LATENCY stages of data+valid.
// Data stages load only alongside a valid bit, so the output word holds
// its last returned value while readdatavalid is low.
module sysid_read_pipe #(
  parameter int LATENCY = 1,
  parameter int WIDTH   = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o
);

  logic [LATENCY-1:0] valid_q;
  logic [WIDTH-1:0]   data_q [LATENCY];

  // Shift the accepted read result toward the output, one stage per clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid_i;
      if (in_valid_i) data_q[0] <= in_data_i;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign out_valid_o = valid_q[LATENCY-1];
  assign out_data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/multicore_sysid_regs.sv
// System-ID register block for the multicore Sobel platform: identity
// words, a 64-bit uptime counter with coherent LO/HI reads, one scratch
// word per core, and a configurable-latency read return path.
module multicore_sysid_regs
  import multicore_sysid_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID    = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
  parameter int          NUM_CORES    = 4,
  parameter logic [7:0]  VERSION      = 8'h02,
  parameter int          ADDR_W       = 4,   // 2**ADDR_W must cover 6+NUM_CORES words
  parameter int          READ_LATENCY = 1
) (
  input logic                    clock,
  input logic                    reset,
  multicore_sysid_regs_if.slave  bus
);

  logic [ADDR_W-1:0] addr;
  assign addr = bus.address;

  logic        en_q, en_d;
  logic [63:0] uptime_q, uptime_d;
  word_t       hi_shadow_q, hi_shadow_d;
  word_t       scratch_q [NUM_CORES];
  word_t       scratch_d [NUM_CORES];
  word_t       rd_data;

  // Select the read word from the current (pre-write) register state.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    rd_data = '0;
    case (addr)
      ADDR_W'(ADDR_SYSID): rd_data = SYSTEM_ID;
      ADDR_W'(ADDR_TS):    rd_data = TIMESTAMP;
      ADDR_W'(ADDR_INFO):  rd_data = {16'h0000, VERSION, 8'(NUM_CORES)};
      ADDR_W'(ADDR_CTRL):  rd_data = {31'h0, en_q};
      ADDR_W'(ADDR_UPLO):  rd_data = uptime_q[31:0];
      ADDR_W'(ADDR_UPHI):  rd_data = hi_shadow_q;
      default: ;
    endcase
    for (int i = 0; i < NUM_CORES; i++) begin
      if (addr == ADDR_W'(ADDR_SCRATCH0 + i)) rd_data = scratch_q[i];
    end
  end

  // Next-state: counter increment, CTRL/scratch writes, HI shadow capture.
  always_comb begin
    en_d        = en_q;
    uptime_d    = en_q ? uptime_q + 64'd1 : uptime_q;
    hi_shadow_d = hi_shadow_q;
    for (int i = 0; i < NUM_CORES; i++) scratch_d[i] = scratch_q[i];

    // Reading LO freezes the matching HI half for a following UPTIME_HI read.
    if (bus.read && addr == ADDR_W'(ADDR_UPLO)) hi_shadow_d = uptime_q[63:32];

    if (bus.write) begin
      // CTRL only has bits in lane 0; a write without that lane does nothing.
      if (addr == ADDR_W'(ADDR_CTRL) && bus.byteenable[0]) begin
        en_d = bus.writedata[CTRL_EN];
        if (bus.writedata[CTRL_CLR]) uptime_d = '0;
      end
      for (int i = 0; i < NUM_CORES; i++) begin
        if (addr == ADDR_W'(ADDR_SCRATCH0 + i))
          scratch_d[i] = apply_byteenable(scratch_q[i], bus.writedata, bus.byteenable);
      end
    end
  end

  // Register state update with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state registers use non-blocking assignment so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (reset) begin
      en_q        <= 1'b1;
      uptime_q    <= '0;
      hi_shadow_q <= '0;
      // NOTE: the scratch array is a handful of flops, not a RAM macro,
      // so it is reset like any other register and software sees zeros.
      for (int i = 0; i < NUM_CORES; i++) scratch_q[i] <= '0;
    end else begin
      en_q        <= en_d;
      uptime_q    <= uptime_d;
      hi_shadow_q <= hi_shadow_d;
      for (int i = 0; i < NUM_CORES; i++) scratch_q[i] <= scratch_d[i];
    end
  end

  sysid_read_pipe #(
    .LATENCY (READ_LATENCY),
    .WIDTH   (32)
  ) u_read_pipe (
    .clock       (clock),
    .reset       (reset),
    .in_valid_i  (bus.read),
    .in_data_i   (rd_data),
    .out_valid_o (bus.readdatavalid),
    .out_data_o  (bus.readdata)
  );

endmodule

// File: doc/multicore_sysid_regs.md
Name: multicore_sysid_regs

Overview:
- Parametrised Avalon-MM slave: next-generation system-ID block for the multicore Sobel platform.
- Read-only identity words: SYSTEM_ID, TIMESTAMP, INFO.
- 64-bit uptime counter with coherent low/high read.
- One read/write scratch/mailbox word per core.
- Configurable read pipeline latency with readdatavalid; sits on the shared peripheral interconnect, reachable by all Nios II cores.

Parameters:
- SYSTEM_ID, 32'h0000_0000: value returned at word 0.
- TIMESTAMP, 32'h0000_0000: build timestamp returned at word 1.
- NUM_CORES, 4: scratch words instantiated (1..16).
- VERSION, 8'h02: block version in INFO[15:8].
- ADDR_W, 4: word-address width; must satisfy 2^ADDR_W >= 6+NUM_CORES.
- READ_LATENCY, 1: cycles from read accept to readdatavalid (1..4).

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  ADDR_W  word address.
- read  in  1  read strobe, accepted every cycle (no waitrequest).
- write  in  1  write strobe, accepted every cycle.
- writedata  in  32  write data.
- byteenable  in  4  byte lanes for writes.
- readdata  out  32  read data, valid when readdatavalid=1.
- readdatavalid  out  1  one-cycle pulse per accepted read.

Behaviour:
- Reset (asynchronous assert, synchronous-release use assumed upstream):
  - readdata=0, readdatavalid=0, read pipeline flushed.
  - uptime=0, hi_shadow=0, CTRL.EN=1, all scratch=0.
- Register map (word address):
  - 0 SYSTEM_ID (ro).
  - 1 TIMESTAMP (ro).
  - 2 INFO (ro): [7:0]=NUM_CORES, [15:8]=VERSION, [31:16]=0.
  - 3 CTRL: bit0 EN (rw); bit1 CLR (write-1, self-clearing, reads 0); other bits read 0.
  - 4 UPTIME_LO (ro).
  - 5 UPTIME_HI (ro, returns hi_shadow).
  - 6..5+NUM_CORES SCRATCH[i] (rw).
  - All other addresses: read 0, writes ignored.
- Read path:
  - Data is selected combinationally at the accept cycle T and pushed through a READ_LATENCY-deep register pipeline.
  - readdata/readdatavalid appear at T+READ_LATENCY.
  - Back-to-back reads are fully pipelined: one result per cycle, in order.
  - When readdatavalid=0, readdata holds its last value (not required to be 0).
- Uptime counter:
  - 64-bit; increments by 1 each clock while EN=1; wraps 2^64-1 -> 0 silently.
  - A read of word 4 captures the current uptime[63:32] into hi_shadow in the same accept cycle, so a LO-then-HI read pair is coherent.
  - A read of word 5 alone returns a stale shadow; this is the intended behaviour.
- Writes:
  - Take effect at the next clock edge and honour byteenable per lane.
  - CTRL write with byteenable[0]=0 is ignored.
  - CTRL write with CLR=1: uptime=0 at the next edge, overriding that cycle's increment; the EN bit in the same write is also applied, so counting resumes from 0 on the following cycle if EN=1.
  - hi_shadow is not affected by CLR.
- Simultaneous read and write in one cycle: both are accepted. The write commits at the edge; the read returns the pre-write value.
- Reset mid-transaction: in-flight reads are dropped; no readdatavalid is produced after reset for reads accepted before reset.

Decomposition:
- Package multicore_sysid_pkg:
  - address constants: ADDR_SYSID=0, ADDR_TS=1, ADDR_INFO=2, ADDR_CTRL=3, ADDR_UPLO=4, ADDR_UPHI=5, ADDR_SCRATCH0=6.
  - CTRL bit indices: EN=0, CLR=1.
  - function applying byteenable to a 32-bit word.
- One sub-module, sysid_read_pipe: a parametrised READ_LATENCY-stage data+valid shift register with async reset.

Test Plan:
- Reset release, READ_LATENCY=2, SYSTEM_ID=32'h5835_0A11: read addr 0 at cycle T -> readdatavalid=1 with readdata=32'h5835_0A11 exactly at T+2; read addr 2 -> 32'h0000_0204.
- Write SCRATCH1=32'hDEAD_BEEF with byteenable=4'b0101, then read -> 32'h00AD_00EF. Back-to-back reads of addr 6,7,8 return in order on 3 consecutive valid cycles.
- EN=1, read LO then HI ten cycles apart with uptime forced near 32'hFFFF_FFFF boundary -> HI equals the value at the LO accept, not the later incremented value.
- Write CTRL=32'h3 (CLR+EN) -> uptime reads 0 one cycle after the edge, then counts. Write CTRL=0 -> LO value stable across reads 20 cycles apart.
- Read and write SCRATCH0 in the same cycle (old 1, new 2) -> that read returns 1; next read returns 2. Read of unmapped addr 15 -> 0; write to addr 15 has no effect.
- Assert reset with 2 reads in flight -> no readdatavalid after reset; all registers at reset values; CTRL reads 1.
